ps2_keycmd_tracker: RTL and testbench

Stateful PS/2 command-key tracker between the PS/2 byte receiver and the keyboard consumers (text editor, menu logic). Consumes the raw scan-code byte stream, assembles multi-byte make/break sequences (E0 prefix, F0 break), and emits one registered event per completed key. It also maintains held state of modifier keys and toggle state of the three lock keys. Function-key decoding width, prefix timeout and repeat filtering are configurable.

---
 rtl/ps2_keycmd_pkg.sv | 50 +++++
 rtl/ps2_keycmd_decode.sv | 65 ++++++
 rtl/ps2_keycmd_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_keycmd_tracker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keycmd_pkg.sv
// Shared types and constants for the PS/2 command-key tracker.
// Optional repeat filtering is enabled with PS2_KEYCMD_REPEAT_FILTER_EN
// (see ps2_keycmd_tracker.sv).
package ps2_keycmd_pkg;

    typedef enum logic [5:0] {
        KC_NONE = 6'd0,
        KC_CTRL, KC_ALT, KC_SHFT,
        KC_ENTR, KC_BKSP, KC_DEL, KC_ESC, KC_TAB,
        KC_CSLK, KC_NMLK, KC_SLLK,
        KC_INSR, KC_HOME, KC_END, KC_PGUP, KC_PGDN,
        KC_UP, KC_DOWN, KC_LEFT, KC_RGHT, KC_PTSC,
        KC_F1, KC_F2, KC_F3, KC_F4, KC_F5, KC_F6,
        KC_F7, KC_F8, KC_F9, KC_F10, KC_F11, KC_F12
    } keycmd_e;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_state_e;

    // Scan-code prefix bytes
    localparam logic [7:0] PFX_E0 = 8'he0;
    localparam logic [7:0] PFX_F0 = 8'hf0;
    localparam logic [7:0] PFX_E1 = 8'he1;

    // Bit positions in the held-modifier mask
    localparam int HB_LCTRL = 0;
    localparam int HB_RCTRL = 1;
    localparam int HB_LALT  = 2;
    localparam int HB_RALT  = 3;
    localparam int HB_LSHFT = 4;
    localparam int HB_RSHFT = 5;

    // Bit positions in the lock registers
    localparam int LK_CAPS   = 0;
    localparam int LK_NUM    = 1;
    localparam int LK_SCROLL = 2;

    // F<n> maps to KC_FKEY_BASE + n
    localparam logic [5:0] KC_FKEY_BASE = KC_F1 - 6'd1;

    // Keyboard-generated fake shifts around extended keys carry no meaning
    function automatic logic is_fake_shift(input logic [15:0] code);
        return (code == 16'he012) || (code == 16'he059);
    endfunction

endpackage

// File: rtl/ps2_keycmd_decode.sv
// Combinational map from an assembled 16-bit scan code to a keycmd_e.
// Function keys beyond F<P_FKEYS> decode to KC_NONE.
module ps2_keycmd_decode
    import ps2_keycmd_pkg::*;
#(
    parameter int P_FKEYS = 12
) (
    input  logic [15:0] code,
    output keycmd_e     evt
);

    logic [3:0] fnum;

    // Function-key number (1..12) for this code, 0 if not a function key
    always_comb begin
        fnum = 4'd0;
        case (code)
            16'h0005: fnum = 4'd1;
            16'h0006: fnum = 4'd2;
            16'h0004: fnum = 4'd3;
            16'h000c: fnum = 4'd4;
            16'h0003: fnum = 4'd5;
            16'h000b: fnum = 4'd6;
            16'h0083: fnum = 4'd7;
            16'h000a: fnum = 4'd8;
            16'h0001: fnum = 4'd9;
            16'h0009: fnum = 4'd10;
            16'h0078: fnum = 4'd11;
            16'h0007: fnum = 4'd12;
            default:  fnum = 4'd0;
        endcase
    end

    // Command-key lookup; function keys override when within the decoded range
    always_comb begin
        evt = KC_NONE;
        case (code)
            16'h0014, 16'he014: evt = KC_CTRL;
            16'h0011, 16'he011: evt = KC_ALT;
            16'h0012, 16'h0059: evt = KC_SHFT;
            16'h005a, 16'he05a: evt = KC_ENTR;
            16'h0066:           evt = KC_BKSP;
            16'he071:           evt = KC_DEL;
            16'h0076:           evt = KC_ESC;
            16'h000d:           evt = KC_TAB;
            16'h0058:           evt = KC_CSLK;
            16'h0077:           evt = KC_NMLK;
            16'h007e:           evt = KC_SLLK;
            16'he070:           evt = KC_INSR;
            16'he06c:           evt = KC_HOME;
            16'he069:           evt = KC_END;
            16'he07d:           evt = KC_PGUP;
            16'he07a:           evt = KC_PGDN;
            16'he075:           evt = KC_UP;
            16'he072:           evt = KC_DOWN;
            16'he06b:           evt = KC_LEFT;
            16'he074:           evt = KC_RGHT;
            16'he07c:           evt = KC_PTSC;
            default:            evt = KC_NONE;
        endcase
        if (fnum != 4'd0 && int'(fnum) <= P_FKEYS)
            evt = keycmd_e'(KC_FKEY_BASE + {2'b00, fnum});
    end

endmodule

// File: rtl/ps2_keycmd_tracker.sv
// PS/2 command-key tracker: assembles E0/F0 sequences into one registered
// event per key, tracks held modifiers and lock toggles, aborts bad or
// stalled sequences with o_perr.
// Define PS2_KEYCMD_REPEAT_FILTER_EN to drop typematic repeats of held keys.
module ps2_keycmd_tracker
    import ps2_keycmd_pkg::*;
#(
    parameter int P_FKEYS = 12,
    parameter int P_TMO   = 100000,
    parameter int P_TMO_W = $clog2(P_TMO + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_vld,
    input  logic        i_err,
    output logic [15:0] o_key,
    output logic        o_key_vld,
    output logic        o_key_brk,
    output keycmd_e     o_evt,
    output logic [5:0]  o_held,
    output logic        o_ctrl,
    output logic        o_alt,
    output logic        o_shft,
    output logic        o_cslk,
    output logic        o_nmlk,
    output logic        o_sllk,
    output logic        o_perr
);

    ps2_state_e         state_q, state_d;
    logic [P_TMO_W-1:0] tmo_q, tmo_d;
    logic               done, done_brk, perr_d;
    logic [15:0]        done_code;
    keycmd_e            dec_evt;
    logic               mod_hit, lock_hit;
    logic [2:0]         mod_idx;
    logic [1:0]         lock_idx;
    logic               commit, filtered, emit;
    logic [5:0]         held_q;
    logic [2:0]         lock_q, lock_held_q;

    ps2_keycmd_decode #(.P_FKEYS(P_FKEYS)) u_decode (
        .code (done_code),
        .evt  (dec_evt)
    );

    // Parser state and inter-byte timeout counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Sequence assembly: errors first, then bytes, then timeout
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        perr_d    = 1'b0;
        done      = 1'b0;
        done_brk  = 1'b0;
        done_code = 16'h0000;
        if (i_err) begin
            perr_d  = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
        end else if (i_vld) begin
            tmo_d = '0;
            if (i_data == PFX_E1) begin
                perr_d  = 1'b1;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_data == PFX_E0)      state_d = EXT;
                        else if (i_data == PFX_F0) state_d = BRK;
                        else begin
                            done      = 1'b1;
                            done_code = {8'h00, i_data};
                        end
                    end
                    EXT: begin
                        if (i_data == PFX_F0)      state_d = EXT_BRK;
                        else if (i_data == PFX_E0) perr_d = 1'b1;
                        else begin
                            done      = 1'b1;
                            done_code = {PFX_E0, i_data};
                            state_d   = IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_d = IDLE;
                        if (i_data == PFX_E0 || i_data == PFX_F0) perr_d = 1'b1;
                        else begin
                            done      = 1'b1;
                            done_brk  = 1'b1;
                            done_code = {(state_q == EXT_BRK) ? PFX_E0 : 8'h00, i_data};
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == P_TMO_W'(P_TMO - 1)) begin
                perr_d  = 1'b1;
                state_d = IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Classify the completed code as modifier or lock key
    always_comb begin
        mod_hit  = 1'b1;
        mod_idx  = 3'd0;
        lock_hit = 1'b1;
        lock_idx = 2'd0;
        case (done_code)
            16'h0014: mod_idx = 3'(HB_LCTRL);
            16'he014: mod_idx = 3'(HB_RCTRL);
            16'h0011: mod_idx = 3'(HB_LALT);
            16'he011: mod_idx = 3'(HB_RALT);
            16'h0012: mod_idx = 3'(HB_LSHFT);
            16'h0059: mod_idx = 3'(HB_RSHFT);
            default:  mod_hit = 1'b0;
        endcase
        case (done_code)
            16'h0058: lock_idx = 2'(LK_CAPS);
            16'h0077: lock_idx = 2'(LK_NUM);
            16'h007e: lock_idx = 2'(LK_SCROLL);
            default:  lock_hit = 1'b0;
        endcase
    end

    assign commit = done && !is_fake_shift(done_code);
    assign emit   = commit && !filtered;

`ifdef PS2_KEYCMD_REPEAT_FILTER_EN
    logic [15:0] last_code_q;
    logic        last_vld_q;

    // A make for something already held is a typematic repeat: drop it
    always_comb begin
        filtered = 1'b0;
        if (!done_brk) begin
            if (mod_hit)       filtered = held_q[mod_idx];
            else if (lock_hit) filtered = lock_held_q[lock_idx];
            else               filtered = last_vld_q && (last_code_q == done_code);
        end
    end

    // Remember the last ordinary make; any break forgets it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_code_q <= 16'h0000;
            last_vld_q  <= 1'b0;
        end else if (commit) begin
            if (done_brk) begin
                last_vld_q <= 1'b0;
            end else if (!mod_hit && !lock_hit) begin
                last_code_q <= done_code;
                last_vld_q  <= 1'b1;
            end
        end
    end
`else
    assign filtered = 1'b0;
`endif

    // Registered event outputs plus held-modifier and lock tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_key       <= 16'h0000;
            o_key_vld   <= 1'b0;
            o_key_brk   <= 1'b0;
            o_evt       <= KC_NONE;
            o_perr      <= 1'b0;
            held_q      <= 6'b0;
            lock_q      <= 3'b0;
            lock_held_q <= 3'b0;
        end else begin
            o_key_vld <= emit;
            o_perr    <= perr_d;
            if (emit) begin
                o_key     <= done_code;
                o_key_brk <= done_brk;
                o_evt     <= dec_evt;
            end
            if (commit && mod_hit)
                held_q[mod_idx] <= !done_brk;
            if (commit && lock_hit) begin
                // Toggle only on the first make; auto-repeat makes while held don't count
                if (!done_brk && !lock_held_q[lock_idx])
                    lock_q[lock_idx] <= !lock_q[lock_idx];
                lock_held_q[lock_idx] <= !done_brk;
            end
        end
    end

    assign o_held = held_q;
    assign o_ctrl = held_q[HB_LCTRL] | held_q[HB_RCTRL];
    assign o_alt  = held_q[HB_LALT]  | held_q[HB_RALT];
    assign o_shft = held_q[HB_LSHFT] | held_q[HB_RSHFT];
    assign o_cslk = lock_q[LK_CAPS];
    assign o_nmlk = lock_q[LK_NUM];
    assign o_sllk = lock_q[LK_SCROLL];

endmodule

// File: tb/tb_ps2_keycmd_tracker.sv
// Self-checking bench for ps2_keycmd_tracker: table of byte sequences with
// expected events/held/lock state, plus hand-written corner sequences.
// Events are scoreboarded: expectations queued at drive time, observed
// pulses captured by a monitor and paired off afterwards.
module tb_ps2_keycmd_tracker;
    import ps2_keycmd_pkg::*;

    localparam int P_FKEYS = 10;
    localparam int P_TMO   = 20;
`ifdef PS2_KEYCMD_REPEAT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        vld = 1'b0;
    logic        err = 1'b0;
    logic [15:0] o_key;
    logic        o_key_vld, o_key_brk, o_perr;
    keycmd_e     o_evt;
    logic [5:0]  o_held;
    logic        o_ctrl, o_alt, o_shft, o_cslk, o_nmlk, o_sllk;

    always #5 clk = ~clk;

    ps2_keycmd_tracker #(.P_FKEYS(P_FKEYS), .P_TMO(P_TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_vld(vld), .i_err(err),
        .o_key(o_key), .o_key_vld(o_key_vld), .o_key_brk(o_key_brk),
        .o_evt(o_evt), .o_held(o_held), .o_ctrl(o_ctrl), .o_alt(o_alt),
        .o_shft(o_shft), .o_cslk(o_cslk), .o_nmlk(o_nmlk), .o_sllk(o_sllk),
        .o_perr(o_perr)
    );

    typedef struct packed {
        logic        perr;
        logic [15:0] key;
        logic        brk;
        logic [5:0]  evt;
    } ev_t;

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic        emit;
        logic [15:0] key;
        logic        brk;
        keycmd_e     evt;
        logic [5:0]  held;
        logic [2:0]  lk;
    } vec_t;

    localparam ev_t PERR = '{perr: 1'b1, key: 16'h0, brk: 1'b0, evt: 6'h0};

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t tv[$];
    int   rd_idx = 0;
    int   checks = 0;
    int   errors = 0;

    // Capture every output pulse; only this process writes obs_q
    always @(negedge clk) begin
        if (o_perr)         obs_q.push_back(PERR);
        else if (o_key_vld) obs_q.push_back('{1'b0, o_key, o_key_brk, o_evt});
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [23:0] b, input int n, input logic emit,
                                input logic [15:0] key, input logic brk, input keycmd_e evt,
                                input logic [5:0] held, input logic [2:0] lk);
        vec_t v;
        v.bytes = b; v.n = n; v.emit = emit; v.key = key; v.brk = brk;
        v.evt = evt; v.held = held; v.lk = lk;
        return v;
    endfunction

    function automatic ev_t mkev(input logic [15:0] key, input logic brk, input keycmd_e evt);
        return '{1'b0, key, brk, evt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_seq(input logic [23:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            data = b[8*(n-1-k) +: 8];
            vld  = 1'b1;
            tick(1);
        end
        vld  = 1'b0;
        data = 8'h00;
    endtask

    // Pair observed pulses with queued expectations
    task automatic drain(input string nm);
        int n_obs;
        tick(2);
        n_obs = obs_q.size() - rd_idx;
        chk({nm, "_count"}, 32'(n_obs), 32'(exp_q.size()));
        while (rd_idx < obs_q.size() && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q[rd_idx];
            rd_idx++;
            e = exp_q.pop_front();
            chk({nm, "_event"}, {8'h00, o}, {8'h00, e});
        end
        rd_idx = obs_q.size();
        exp_q.delete();
    endtask

    task automatic chk_state(input string nm, input logic [5:0] held, input logic [2:0] lk);
        chk({nm, "_held"}, 32'(o_held), 32'(held));
        chk({nm, "_mods"}, 32'({o_shft, o_alt, o_ctrl}),
            32'({|held[5:4], |held[3:2], |held[1:0]}));
        chk({nm, "_lock"}, 32'({o_sllk, o_nmlk, o_cslk}), 32'(lk));
    endtask

    initial begin
        int first;

        // Reset values
        tick(2);
        chk("rst_key", 32'(o_key), 32'h0);
        chk("rst_key_vld", 32'(o_key_vld), 32'h0);
        chk("rst_key_brk", 32'(o_key_brk), 32'h0);
        chk("rst_evt", 32'(o_evt), 32'(KC_NONE));
        chk("rst_perr", 32'(o_perr), 32'h0);
        chk_state("rst", 6'b0, 3'b0);
        rst = 1'b0;
        tick(1);

        // Table: bytes, count, emits, key, brk, evt, held after, locks {sl,nm,cs} after
        tv.push_back(mk(24'h000014, 1, 1, 16'h0014, 0, KC_CTRL, 6'b000001, 3'b000));
        tv.push_back(mk(24'h00f014, 2, 1, 16'h0014, 1, KC_CTRL, 6'b000000, 3'b000));
        tv.push_back(mk(24'h00e075, 2, 1, 16'he075, 0, KC_UP,   6'b000000, 3'b000));
        tv.push_back(mk(24'he0f075, 3, 1, 16'he075, 1, KC_UP,   6'b000000, 3'b000));
        tv.push_back(mk(24'h000058, 1, 1, 16'h0058, 0, KC_CSLK, 6'b000000, 3'b001));
        tv.push_back(mk(24'h00f058, 2, 1, 16'h0058, 1, KC_CSLK, 6'b000000, 3'b001));
        tv.push_back(mk(24'h000058, 1, 1, 16'h0058, 0, KC_CSLK, 6'b000000, 3'b000));
        tv.push_back(mk(24'h00f058, 2, 1, 16'h0058, 1, KC_CSLK, 6'b000000, 3'b000));
        tv.push_back(mk(24'h00e014, 2, 1, 16'he014, 0, KC_CTRL, 6'b000010, 3'b000));
        tv.push_back(mk(24'h000059, 1, 1, 16'h0059, 0, KC_SHFT, 6'b100010, 3'b000));
        tv.push_back(mk(24'h00e012, 2, 0, 16'h0000, 0, KC_NONE, 6'b100010, 3'b000));
        tv.push_back(mk(24'he0f012, 3, 0, 16'h0000, 0, KC_NONE, 6'b100010, 3'b000));
        tv.push_back(mk(24'h00e059, 2, 0, 16'h0000, 0, KC_NONE, 6'b100010, 3'b000));
        tv.push_back(mk(24'he0f059, 3, 0, 16'h0000, 0, KC_NONE, 6'b100010, 3'b000));
        tv.push_back(mk(24'h00f059, 2, 1, 16'h0059, 1, KC_SHFT, 6'b000010, 3'b000));
        tv.push_back(mk(24'he0f014, 3, 1, 16'he014, 1, KC_CTRL, 6'b000000, 3'b000));
        tv.push_back(mk(24'h000011, 1, 1, 16'h0011, 0, KC_ALT,  6'b000100, 3'b000));
        tv.push_back(mk(24'h00e011, 2, 1, 16'he011, 0, KC_ALT,  6'b001100, 3'b000));
        tv.push_back(mk(24'h000012, 1, 1, 16'h0012, 0, KC_SHFT, 6'b011100, 3'b000));
        tv.push_back(mk(24'h00f011, 2, 1, 16'h0011, 1, KC_ALT,  6'b011000, 3'b000));
        tv.push_back(mk(24'he0f011, 3, 1, 16'he011, 1, KC_ALT,  6'b010000, 3'b000));
        tv.push_back(mk(24'h00f012, 2, 1, 16'h0012, 1, KC_SHFT, 6'b000000, 3'b000));
        tv.push_back(mk(24'h000077, 1, 1, 16'h0077, 0, KC_NMLK, 6'b000000, 3'b010));
        tv.push_back(mk(24'h00007e, 1, 1, 16'h007e, 0, KC_SLLK, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00f077, 2, 1, 16'h0077, 1, KC_NMLK, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00f07e, 2, 1, 16'h007e, 1, KC_SLLK, 6'b000000, 3'b110));
        tv.push_back(mk(24'h000005, 1, 1, 16'h0005, 0, KC_F1,   6'b000000, 3'b110));
        tv.push_back(mk(24'h000083, 1, 1, 16'h0083, 0, KC_F7,   6'b000000, 3'b110));
        tv.push_back(mk(24'h000001, 1, 1, 16'h0001, 0, KC_F9,   6'b000000, 3'b110));
        tv.push_back(mk(24'h000009, 1, 1, 16'h0009, 0, KC_F10,  6'b000000, 3'b110));
        tv.push_back(mk(24'h000078, 1, 1, 16'h0078, 0, KC_NONE, 6'b000000, 3'b110));
        tv.push_back(mk(24'h000007, 1, 1, 16'h0007, 0, KC_NONE, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00005a, 1, 1, 16'h005a, 0, KC_ENTR, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e05a, 2, 1, 16'he05a, 0, KC_ENTR, 6'b000000, 3'b110));
        tv.push_back(mk(24'h000066, 1, 1, 16'h0066, 0, KC_BKSP, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e071, 2, 1, 16'he071, 0, KC_DEL,  6'b000000, 3'b110));
        tv.push_back(mk(24'h000076, 1, 1, 16'h0076, 0, KC_ESC,  6'b000000, 3'b110));
        tv.push_back(mk(24'h00000d, 1, 1, 16'h000d, 0, KC_TAB,  6'b000000, 3'b110));
        tv.push_back(mk(24'h00e070, 2, 1, 16'he070, 0, KC_INSR, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e06c, 2, 1, 16'he06c, 0, KC_HOME, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e069, 2, 1, 16'he069, 0, KC_END,  6'b000000, 3'b110));
        tv.push_back(mk(24'h00e07d, 2, 1, 16'he07d, 0, KC_PGUP, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e07a, 2, 1, 16'he07a, 0, KC_PGDN, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e072, 2, 1, 16'he072, 0, KC_DOWN, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e06b, 2, 1, 16'he06b, 0, KC_LEFT, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e074, 2, 1, 16'he074, 0, KC_RGHT, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00e07c, 2, 1, 16'he07c, 0, KC_PTSC, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00007c, 1, 1, 16'h007c, 0, KC_NONE, 6'b000000, 3'b110));
        tv.push_back(mk(24'h00001c, 1, 1, 16'h001c, 0, KC_NONE, 6'b000000, 3'b110));
        tv.push_back(mk(24'he0f01c, 3, 1, 16'he01c, 1, KC_NONE, 6'b000000, 3'b110));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].emit) exp_q.push_back(mkev(tv[i].key, tv[i].brk, tv[i].evt));
            send_seq(tv[i].bytes, tv[i].n);
            drain($sformatf("vec%0d", i));
            chk_state($sformatf("vec%0d", i), tv[i].held, tv[i].lk);
        end
        chk("hold_key", 32'(o_key), 32'he01c);
        chk("hold_brk", 32'(o_key_brk), 32'h1);

        // Timeout: E0 then silence; abort decided on the P_TMO-th idle cycle
        exp_q.push_back(PERR);
        send_seq(24'h0000e0, 1);
        first = -1;
        for (int k = 1; k <= P_TMO + 4; k++) begin
            @(negedge clk);
            if (o_perr && first < 0) first = k;
        end
        @(posedge clk);
        #1;
        chk("tmo_cycle", 32'(first), 32'(P_TMO + 1));
        drain("tmo");
        exp_q.push_back(mkev(16'h0005, 0, KC_F1));
        send_seq(24'h000005, 1);
        drain("tmo_then_f1");

        // A byte arriving on the last allowed cycle beats the timeout
        exp_q.push_back(mkev(16'he075, 0, KC_UP));
        send_seq(24'h0000e0, 1);
        tick(P_TMO - 1);
        send_seq(24'h000075, 1);
        drain("tmo_vld_wins");

        // Frame error mid-break, then a clean make
        exp_q.push_back(PERR);
        send_seq(24'h0000f0, 1);
        err = 1'b1;
        tick(1);
        err = 1'b0;
        drain("err_brk");
        exp_q.push_back(mkev(16'h005a, 0, KC_ENTR));
        send_seq(24'h00005a, 1);
        drain("err_then_make");

        // Error with a simultaneous byte: byte ignored
        exp_q.push_back(PERR);
        err = 1'b1; vld = 1'b1; data = 8'h14;
        tick(1);
        err = 1'b0; vld = 1'b0; data = 8'h00;
        drain("err_vld");
        chk_state("err_vld", 6'b0, 3'b110);

        // Pause prefix aborts; E0 E0 aborts but stays extended; F0 E0 returns to idle
        exp_q.push_back(PERR);
        send_seq(24'h0000e1, 1);
        drain("e1_idle");
        exp_q.push_back(PERR);
        exp_q.push_back(mkev(16'h0075, 0, KC_NONE));
        send_seq(24'h00e0e1, 2);
        send_seq(24'h000075, 1);
        drain("e1_ext");
        exp_q.push_back(PERR);
        exp_q.push_back(mkev(16'he075, 0, KC_UP));
        send_seq(24'he0e075, 3);
        drain("e0_e0");
        exp_q.push_back(PERR);
        exp_q.push_back(mkev(16'h0075, 0, KC_NONE));
        send_seq(24'hf0e075, 3);
        drain("f0_e0");
        exp_q.push_back(PERR);
        exp_q.push_back(mkev(16'h0014, 0, KC_CTRL));
        send_seq(24'he0f0f0, 3);
        send_seq(24'h000014, 1);
        drain("ebrk_f0");
        chk_state("ebrk_f0", 6'b000001, 3'b110);
        exp_q.push_back(mkev(16'h0014, 1, KC_CTRL));
        send_seq(24'h00f014, 2);
        drain("ebrk_f0_rel");

        // Typematic repeats: modifier, lock, ordinary key
        exp_q.push_back(mkev(16'h0014, 0, KC_CTRL));
        if (!FILT) exp_q.push_back(mkev(16'h0014, 0, KC_CTRL));
        exp_q.push_back(mkev(16'h0014, 1, KC_CTRL));
        send_seq(24'h001414, 2);
        send_seq(24'h00f014, 2);
        drain("rep_ctrl");
        exp_q.push_back(mkev(16'h0058, 0, KC_CSLK));
        if (!FILT) exp_q.push_back(mkev(16'h0058, 0, KC_CSLK));
        exp_q.push_back(mkev(16'h0058, 1, KC_CSLK));
        send_seq(24'h005858, 2);
        send_seq(24'h00f058, 2);
        drain("rep_caps");
        chk_state("rep_caps", 6'b0, 3'b111);
        exp_q.push_back(mkev(16'h001c, 0, KC_NONE));
        if (!FILT) exp_q.push_back(mkev(16'h001c, 0, KC_NONE));
        exp_q.push_back(mkev(16'h001c, 1, KC_NONE));
        send_seq(24'h001c1c, 2);
        send_seq(24'h00f01c, 2);
        drain("rep_key");

        // Reset mid-sequence: partial sequence dropped, no abort pulse
        exp_q.push_back(mkev(16'h0014, 0, KC_CTRL));
        send_seq(24'h000014, 1);
        drain("pre_rst");
        chk_state("pre_rst", 6'b000001, 3'b111);
        send_seq(24'h0000e0, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        drain("rst_mid");
        chk_state("rst_mid", 6'b0, 3'b0);
        chk("rst_mid_key", 32'(o_key), 32'h0);
        chk("rst_mid_evt", 32'(o_evt), 32'(KC_NONE));
        exp_q.push_back(mkev(16'h0075, 0, KC_NONE));
        send_seq(24'h000075, 1);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
